mse_serial_master: RTL and testbench
====================================

Name: mse_serial_master

Overview:
Per-lane serial transfer engine that sits directly upstream of the MSE pad interconnect. It drives that lane's SDI/SLE inputs and direction enables, and consumes the lane's SDO/SRDY pad readback. A parallel word is handed in with a valid/ready handshake and shifted out on SDI under an SLE frame, gated by the slave's SRDY. SDO is sampled concurrently and the received word is returned in parallel. The top level instantiates seven, one per lane index 0..6.

Parameters:
DATA_W, 16, bits per transfer (2..32).
CLK_DIV, 4, clk cycles per serial bit; even, >=2.
TIMEOUT, 1024, max clk cycles spent waiting for SRDY before abort (>=1).
MSB_FIRST, 1, 1 = shift/receive MSB first, 0 = LSB first.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
tx_data  in  DATA_W  word to transmit.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  engine idle and able to accept a word.
rx_data  out  DATA_W  word sampled from SDO; held until the next rx_valid.
rx_valid  out  1  one-cycle pulse; rx_data is valid.
timeout_err  out  1  one-cycle pulse; SRDY wait aborted.
busy  out  1  high in every state except IDLE.
sdi_i  out  1  serial data to MSE_SDI_i[n].
sdi_dir  out  1  to MSE_SDI_dir[n].
sdo_i  out  1  to MSE_SDO_i[n]; constant 0.
sdo_dir  out  1  to MSE_SDO_dir[n].
sdo_o  in  1  from MSE_SDO_o[n]; slave serial data.
sle_i  out  1  latch-enable frame to MSE_SLE_i[n].
sle_dir  out  1  to MSE_SLE_dir[n].
srdy_i  out  1  to MSE_SRDY_i[n]; constant 0.
srdy_dir  out  1  to MSE_SRDY_dir[n].
srdy_o  in  1  from MSE_SRDY_o[n]; slave ready, asynchronous.

Behaviour:
- Reset (async, immediate): all registered outputs 0, including tx_ready, busy, sdi_i, sle_i, rx_data, rx_valid, timeout_err. All pads are tristated: sdi_dir = sle_dir = 0. Counters clear and the state returns to IDLE.
- First clk edge after reset release: sdi_dir and sle_dir go to 1 and tx_ready goes to 1. sdo_dir and srdy_dir stay 0 permanently.
- srdy_o passes through a 2-flop synchroniser (srdy_s) before use. SRDY input latency is 2 cycles.
- IDLE: tx_ready = 1, sle_i = 0, sdi_i = 0. On tx_valid & tx_ready, capture tx_data into the shift register, drop tx_ready the next cycle and go to WAIT_RDY.
- WAIT_RDY: a wait counter increments each cycle.
  - If srdy_s = 1, go to SHIFT.
  - Otherwise, when the counter reaches TIMEOUT, pulse timeout_err for 1 cycle, leave rx_data and rx_valid unchanged, and go to IDLE.
  - If srdy_s = 1 on the same cycle the counter reaches TIMEOUT, SHIFT wins and no error is raised.
- SHIFT: lasts exactly DATA_W*CLK_DIV cycles.
  - sle_i = 1 throughout.
  - sdi_i holds the current bit for CLK_DIV cycles, then the next bit per MSB_FIRST.
  - sdo_o is sampled into the rx shift register on the cycle where div_cnt == CLK_DIV/2-1.
  - SRDY changes during SHIFT are ignored.
  - The bit counter wraps from DATA_W-1 to 0 and moves to LATCH.
- LATCH: sle_i = 0 and sdi_i = 0 for CLK_DIV cycles, which is the slave's latch interval. On the last cycle, load rx_data and pulse rx_valid on the next cycle together with the return to IDLE (tx_ready = 1 on that same cycle).
- Timing from the accept edge to rx_valid: 1 + (SRDY wait) + DATA_W*CLK_DIV + CLK_DIV cycles. With SRDY already stable high, the wait is 2 (synchroniser).
- Back-to-back: a word offered on the rx_valid cycle is accepted. No bubble is required beyond the IDLE cycle.
- tx_valid outside IDLE is ignored; the upstream must hold it until tx_ready.
- Reset asserted mid-SHIFT: the frame aborts immediately (sle_i = 0, pads tristated). No rx_valid or timeout_err is produced.

Decomposition:
- Package mse_pkg holds:
  - state enum {IDLE, WAIT_RDY, SHIFT, LATCH};
  - pad-direction constants DIR_OUT = 1, DIR_IN = 0;
  - lane count MSE_LANES = 7.
- Sub-module mse_sync2: 2-flop synchroniser with async active-low reset, used for srdy_o.

Test Plan:
1. Reset and idle: hold rst_n = 0 for 3 cycles, then release. All outputs are 0 during reset. One cycle after release, tx_ready = 1 and sdi_dir = sle_dir = 1, while sdo_dir = srdy_dir = 0.
2. Basic transfer: DATA_W = 16, CLK_DIV = 4, srdy_o = 1, tx_data = 0xA5C3, slave model loops SDI back to SDO. Expect sle_i high for exactly 64 cycles, SDI bits 1,0,1,0,0,1,0,1,... MSB first, and rx_data = 0xA5C3 with rx_valid 71 cycles after the accept.
3. SRDY gating: srdy_o = 0, send 0x0001, raise srdy_o after 50 cycles. Expect sle_i to rise 3 cycles after srdy_o rises and rx_valid to follow; timeout_err stays 0.
4. Timeout: TIMEOUT = 16, srdy_o = 0. Expect timeout_err to pulse exactly once, 17 cycles after the accept, with no rx_valid, rx_data unchanged, and tx_ready = 1 on the next cycle.
5. Back-to-back and LSB first: MSB_FIRST = 0, send 0x0003 then 0x8000 with tx_valid held high. Expect the second accept on the rx_valid cycle, the first SDI bit of word 2 to be 0, and the rx words to equal the tx words.
6. Reset mid-SHIFT: assert rst_n = 0 on bit 7 of 0xFFFF. Expect sle_i, sdi_dir and sle_dir to drop to 0 in the same cycle, with no rx_valid; a following transfer of 0x1234 completes correctly.

Source files
------------

// File: rtl/mse_pkg.sv
`default_nettype none
// ============================================================================
// Module : mse_pkg
// Brief  : Shared types and constants for the MSE per-lane serial master.
// Rev    : 1.0  initial release
// ============================================================================
package mse_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    SHIFT    = 2'd2,
    LATCH    = 2'd3
  } mse_state_t;

  localparam logic DIR_OUT     = 1'b1;
  localparam logic DIR_IN      = 1'b0;
  localparam int   MSE_LANES   = 7;
  localparam int   SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/mse_sync2.sv
`default_nettype none
// ============================================================================
// Module : mse_sync2
// Brief  : Two-flop synchroniser with asynchronous active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
module mse_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/mse_serial_master.sv
`default_nettype none
// ============================================================================
// Module : mse_serial_master
// Brief  : Per-lane MSE serial engine: parallel word out on SDI under an SLE
//          frame gated by SRDY, SDO sampled back into a parallel word.
// Rev    : 1.0  initial release
// ============================================================================
module mse_serial_master
  import mse_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 4,
  parameter int TIMEOUT   = 1024,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_timeout_err,
  output logic              o_busy,
  output logic              o_sdi_i,
  output logic              o_sdi_dir,
  output logic              o_sdo_i,
  output logic              o_sdo_dir,
  input  logic              i_sdo_o,
  output logic              o_sle_i,
  output logic              o_sle_dir,
  output logic              o_srdy_i,
  output logic              o_srdy_dir,
  input  logic              i_srdy_o
);

  localparam int c_DIV_W  = $clog2(CLK_DIV);
  localparam int c_BIT_W  = $clog2(DATA_W);
  localparam int c_WAIT_W = $clog2(TIMEOUT + SYNC_STAGES + 1);

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0]  c_DIV_SAMPLE = c_DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST   = c_BIT_W'(DATA_W - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX   = c_WAIT_W'(TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_FRESH = c_WAIT_W'(SYNC_STAGES);

  mse_state_t          r_state;
  logic [DATA_W-1:0]   r_tx_sh;
  logic [DATA_W-1:0]   r_rx_sh;
  logic [DATA_W-1:0]   r_rx_data;
  logic [c_DIV_W-1:0]  r_div_cnt;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_tx_ready;
  logic                r_rx_valid;
  logic                r_timeout_err;
  logic                r_busy;
  logic                r_sdi;
  logic                r_sle;
  logic                r_pad_en;

  logic                w_srdy_s;
  logic [DATA_W-1:0]   w_tx_shifted;
  logic [DATA_W-1:0]   w_rx_shifted;
  logic                w_first_bit;
  logic                w_next_bit;

  mse_sync2 u_srdy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_srdy_o),
    .o_q   (w_srdy_s)
  );

  assign w_tx_shifted = (MSB_FIRST != 0) ? {r_tx_sh[DATA_W-2:0], 1'b0}
                                         : {1'b0, r_tx_sh[DATA_W-1:1]};
  assign w_rx_shifted = (MSB_FIRST != 0) ? {r_rx_sh[DATA_W-2:0], i_sdo_o}
                                         : {i_sdo_o, r_rx_sh[DATA_W-1:1]};
  assign w_first_bit  = (MSB_FIRST != 0) ? r_tx_sh[DATA_W-1] : r_tx_sh[0];
  assign w_next_bit   = (MSB_FIRST != 0) ? r_tx_sh[DATA_W-2] : r_tx_sh[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_tx_sh       <= '0;
      r_rx_sh       <= '0;
      r_rx_data     <= '0;
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_tx_ready    <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
      r_sdi         <= 1'b0;
      r_sle         <= 1'b0;
      r_pad_en      <= DIR_IN;
    end else begin
      r_pad_en      <= DIR_OUT;
      r_rx_valid    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sle <= 1'b0;
          r_sdi <= 1'b0;
          if (i_tx_valid && r_tx_ready) begin
            r_tx_sh    <= i_tx_data;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= WAIT_RDY;
          end else begin
            r_tx_ready <= 1'b1;
          end
        end
        WAIT_RDY: begin
          // Ready is trusted only once resampled after the accept, so a
          // level left over from the previous frame cannot start this one.
          if (w_srdy_s && (r_wait_cnt >= c_WAIT_FRESH)) begin
            r_sle     <= 1'b1;
            r_sdi     <= w_first_bit;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
          end else if (r_wait_cnt >= c_WAIT_MAX) begin
            r_timeout_err <= 1'b1;
            r_tx_ready    <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (r_div_cnt == c_DIV_SAMPLE) begin
            r_rx_sh <= w_rx_shifted;
          end
          if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
            if (r_bit_cnt == c_BIT_LAST) begin
              r_bit_cnt <= '0;
              r_sle     <= 1'b0;
              r_sdi     <= 1'b0;
              r_state   <= LATCH;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx_sh   <= w_tx_shifted;
              r_sdi     <= w_next_bit;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt  <= '0;
            r_rx_data  <= r_rx_sh;
            r_rx_valid <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tx_ready    = r_tx_ready;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_timeout_err = r_timeout_err;
  assign o_busy        = r_busy;
  assign o_sdi_i       = r_sdi;
  assign o_sle_i       = r_sle;
  assign o_sdi_dir     = r_pad_en;
  assign o_sle_dir     = r_pad_en;
  assign o_sdo_i       = 1'b0;
  assign o_srdy_i      = 1'b0;
  assign o_sdo_dir     = DIR_IN;
  assign o_srdy_dir    = DIR_IN;

endmodule
`default_nettype wire

// File: tb/tb_mse_serial_master.sv
`default_nettype none
// ============================================================================
// Module : tb_mse_serial_master
// Brief  : Scoreboarded bench for two lanes (MSB-first and LSB-first) with an
//          SDI->SDO loopback slave.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mse_serial_master;

  localparam int DW    = 16;
  localparam int CD    = 4;
  localparam int c_LAT = 1 + 2 + DW * CD + CD;
  localparam int c_TO1 = 16;

  typedef struct {
    bit          is_to;
    logic [DW-1:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic srdy_o = 1'b1;
  int   cyc = 0;

  logic [DW-1:0] tx_data [2];
  logic [DW-1:0] rx_data [2];
  logic [1:0] tx_valid, tx_ready, rx_valid, to_err, busy;
  logic [1:0] sdi, sdi_dir, sdo_i, sdo_dir, sle, sle_dir, srdy_i, srdy_dir;

  exp_t          q_rx [2][$];
  logic [DW-1:0] q_fr [2][$];
  logic          samp [2][256];
  int            fcnt [2];
  int            last_out_cyc [2];
  int            n_chk = 0;
  int            n_pass = 0;
  exp_t          me;
  logic [DW-1:0] fw;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mse_serial_master #(.DATA_W(DW), .CLK_DIV(CD), .TIMEOUT(64), .MSB_FIRST(1)) u_lane0 (
    .clk(clk), .rst_n(rst_n),
    .i_tx_data(tx_data[0]), .i_tx_valid(tx_valid[0]), .o_tx_ready(tx_ready[0]),
    .o_rx_data(rx_data[0]), .o_rx_valid(rx_valid[0]), .o_timeout_err(to_err[0]),
    .o_busy(busy[0]), .o_sdi_i(sdi[0]), .o_sdi_dir(sdi_dir[0]),
    .o_sdo_i(sdo_i[0]), .o_sdo_dir(sdo_dir[0]), .i_sdo_o(sdi[0]),
    .o_sle_i(sle[0]), .o_sle_dir(sle_dir[0]),
    .o_srdy_i(srdy_i[0]), .o_srdy_dir(srdy_dir[0]), .i_srdy_o(srdy_o)
  );

  mse_serial_master #(.DATA_W(DW), .CLK_DIV(CD), .TIMEOUT(c_TO1), .MSB_FIRST(0)) u_lane1 (
    .clk(clk), .rst_n(rst_n),
    .i_tx_data(tx_data[1]), .i_tx_valid(tx_valid[1]), .o_tx_ready(tx_ready[1]),
    .o_rx_data(rx_data[1]), .o_rx_valid(rx_valid[1]), .o_timeout_err(to_err[1]),
    .o_busy(busy[1]), .o_sdi_i(sdi[1]), .o_sdi_dir(sdi_dir[1]),
    .o_sdo_i(sdo_i[1]), .o_sdo_dir(sdo_dir[1]), .i_sdo_o(sdi[1]),
    .o_sle_i(sle[1]), .o_sle_dir(sle_dir[1]),
    .o_srdy_i(srdy_i[1]), .o_srdy_dir(srdy_dir[1]), .i_srdy_o(srdy_o)
  );

  task automatic chk(input string nm, input int l, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s lane=%0d got=0x%0h want=0x%0h", nm, l, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int l, input logic [DW-1:0] d, input bit hold,
                      input bit push, input bit to, input int lat, output int acc);
    int n = 0;
    tx_data[l]  = d;
    tx_valid[l] = 1'b1;
    while (!tx_ready[l] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", l, longint'(n < 400), 1);
    acc = cyc + 1;
    if (push) begin
      q_rx[l].push_back('{to, (to ? '0 : d), (lat < 0) ? -1 : acc + lat});
      if (!to) q_fr[l].push_back(d);
    end
    @(negedge clk);
    if (!hold) tx_valid[l] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_rx[0].size() + q_rx[1].size() + q_fr[0].size() + q_fr[1].size()) != 0
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", -1, longint'(n < 2000), 1);
  endtask

  task automatic rand_lane(input int l);
    int a;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(l, DW'($urandom), 1'b0, 1'b1, 1'b0, c_LAT, a);
    end
  endtask

  task automatic wait_sle(input int l);
    int n = 0;
    while (!sle[l] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("sle_seen", l, sle[l], 1);
  endtask

  // Monitor: serial frame reconstruction and parallel output scoreboard.
  initial forever begin
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      if (!rst_n) begin
        fcnt[l] = 0;
      end else begin
        if (rx_valid[l] || to_err[l]) begin
          if (q_rx[l].size() == 0) begin
            chk("unexpected_out", l, {rx_valid[l], to_err[l]}, 0);
          end else begin
            me = q_rx[l].pop_front();
            chk("out_kind", l, {rx_valid[l], to_err[l]}, me.is_to ? 1 : 2);
            if (!me.is_to) chk("rx_data", l, rx_data[l], me.data);
            if (me.cyc >= 0) chk("out_cycle", l, cyc, me.cyc);
          end
          last_out_cyc[l] = cyc;
        end
        if (sle[l]) begin
          if (fcnt[l] < 256) samp[l][fcnt[l]] = sdi[l];
          fcnt[l]++;
        end else if (fcnt[l] != 0) begin
          fw = '0;
          for (int b = 0; b < DW; b++) begin
            if (l == 0) fw[DW-1-b] = samp[l][b*CD];
            else        fw[b]      = samp[l][b*CD];
          end
          chk("sle_len", l, fcnt[l], DW * CD);
          if (q_fr[l].size() == 0) chk("unexpected_frame", l, fw, -1);
          else chk("sdi_word", l, fw, q_fr[l].pop_front());
          fcnt[l] = 0;
        end
      end
    end
  end

  initial begin
    int a1, a2, rise;
    logic [DW-1:0] wb;
    tx_valid = '0;
    tx_data[0] = '0;
    tx_data[1] = '0;

    repeat (3) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      chk("reset_outs", l, {tx_ready[l], busy[l], sdi[l], sle[l], rx_valid[l], to_err[l],
                            sdi_dir[l], sle_dir[l], sdo_dir[l], srdy_dir[l], sdo_i[l], srdy_i[l]}, 0);
      chk("reset_rx_data", l, rx_data[l], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      chk("ready_after_rst", l, tx_ready[l], 1);
      chk("dirs_after_rst", l, {sdi_dir[l], sle_dir[l], sdo_dir[l], srdy_dir[l]}, 4'b1100);
    end
    repeat (2) @(negedge clk);

    send(0, 16'hA5C3, 1'b0, 1'b1, 1'b0, c_LAT, a1);
    drain();

    fork
      rand_lane(0);
      rand_lane(1);
    join
    drain();

    send(1, 16'h0003, 1'b1, 1'b1, 1'b0, c_LAT, a1);
    send(1, 16'h8000, 1'b0, 1'b1, 1'b0, c_LAT, a2);
    chk("b2b_accept_gap", 1, a2 - a1, c_LAT + 1);
    drain();

    srdy_o = 1'b0;
    repeat (4) @(negedge clk);
    send(0, 16'h0001, 1'b0, 1'b1, 1'b0, -1, a1);
    repeat (50) @(negedge clk);
    chk("sle_low_while_gated", 0, sle[0], 0);
    srdy_o = 1'b1;
    rise = cyc;
    wait_sle(0);
    chk("srdy_to_sle", 0, cyc - rise, 3);
    drain();
    chk("gated_rx_cycle", 0, last_out_cyc[0], rise + 3 + DW * CD + CD);

    // Synchronised ready arrives on exactly the cycle the wait limit is hit.
    srdy_o = 1'b0;
    repeat (4) @(negedge clk);
    wb = DW'($urandom);
    send(1, wb, 1'b0, 1'b1, 1'b0, c_TO1 + 1 + DW * CD + CD, a1);
    repeat (c_TO1 - 2) @(negedge clk);
    srdy_o = 1'b1;
    drain();

    srdy_o = 1'b0;
    repeat (4) @(negedge clk);
    send(1, 16'h5A5A, 1'b0, 1'b1, 1'b1, c_TO1 + 1, a1);
    drain();
    chk("rx_hold_after_to", 1, rx_data[1], wb);
    @(negedge clk);
    chk("ready_after_to", 1, tx_ready[1], 1);
    chk("to_pulse_len", 1, to_err[1], 0);

    srdy_o = 1'b1;
    repeat (4) @(negedge clk);
    send(0, 16'hFFFF, 1'b0, 1'b0, 1'b0, -1, a1);
    wait_sle(0);
    repeat (7 * CD + 1) @(negedge clk);
    chk("mid_shift_sle", 0, {sle[0], sdi[0]}, 2'b11);
    #1 rst_n = 1'b0;
    #1 chk("abort_pads", 0, {sle[0], sdi[0], sdi_dir[0], sle_dir[0], busy[0], tx_ready[0]}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", 0, tx_ready[0], 1);
    repeat (3) @(negedge clk);
    send(0, 16'h1234, 1'b0, 1'b1, 1'b0, c_LAT, a1);
    drain();
    repeat (4) @(negedge clk);
    chk("queues_empty", -1, q_rx[0].size() + q_rx[1].size() + q_fr[0].size() + q_fr[1].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
